everloop_fb: RTL and testbench

Double-buffered byte frame buffer feeding the `everloop` LED-ring serializer. The host side writes a complete or partial frame into the hidden bank and commits it. The buffer swaps banks only at an `everloop` frame boundary, so the serializer never shows a torn frame. The read side connects directly to `everloop`: its `address[7:0]` output drives `rd_addr`, and `rd_data` drives its `data_RGB[7:0]` input.

---
 rtl/everloop_pkg.sv | 16 +
 rtl/everloop_fb_if.sv | 27 ++
 rtl/everloop_fb_bank.sv | 29 ++
 rtl/everloop_fb.sv | 144 ++++++++++++++
 tb/tb_everloop_fb.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/everloop_pkg.sv
// rtl/everloop_pkg.sv - shared constants and FSM state type for the everloop frame buffer
package everloop_pkg;

  localparam int N_LEDS        = 35;
  localparam int BYTES_PER_LED = 4;
  localparam int DEPTH         = N_LEDS * BYTES_PER_LED;
  localparam int ADDR_W        = 8;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_PEND,
    ST_COPY
  } state_e;

endpackage

// File: rtl/everloop_fb_if.sv
// rtl/everloop_fb_if.sv - host write port and serializer read port of the frame buffer
interface everloop_fb_if;
  import everloop_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_last;
  logic              wr_err;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              pending;
  logic              bank;
  logic [7:0]        frame_cnt;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_last, rd_addr,
    input  wr_ready, wr_err, rd_data, pending, bank, frame_cnt
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_last, rd_addr,
    output wr_ready, wr_err, rd_data, pending, bank, frame_cnt
  );

endinterface

// File: rtl/everloop_fb_bank.sv
// rtl/everloop_fb_bank.sv - one DEPTH x 8 byte bank, one write port, two async read ports
module everloop_bank
  import everloop_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [7:0]        rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [7:0]        rdata_b_o
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  logic [7:0] mem_q [DEPTH];

  // Byte write; addresses beyond the bank never touch storage
  always_ff @(posedge clk_i) begin
    if (we_i && ({1'b0, waddr_i} < LIMIT)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = ({1'b0, raddr_a_i} < LIMIT) ? mem_q[raddr_a_i] : 8'h00;
  assign rdata_b_o = ({1'b0, raddr_b_i} < LIMIT) ? mem_q[raddr_b_i] : 8'h00;

endmodule

// File: rtl/everloop_fb.sv
// rtl/everloop_fb.sv - double-buffered frame buffer swapping only at everloop frame boundaries
module everloop_fb
  import everloop_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  everloop_fb_if.slave bus
);

  localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              bank_q, bank_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic [ADDR_W-1:0] prev_addr_q;
  logic              wr_ready_q;
  logic              wr_err_q, wr_err_d;
  logic [7:0]        rd_data_q, rd_data_d;

  logic              accept, in_range, boundary, rd_sel;
  logic              wr_w, wr_both, we0, we1;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;
  logic [7:0]        b0_disp, b1_disp, b0_src, b1_src, copy_src;

  assign accept   = bus.wr_valid && wr_ready_q;
  assign in_range = ({1'b0, bus.wr_addr} < LIMIT);
  assign boundary = (bus.rd_addr == '0) && (prev_addr_q == LAST_IDX);
  // In the swapping boundary cycle address 0 must already come from the new bank
  assign rd_sel   = (state_q == ST_PEND && boundary) ? ~bank_q : bank_q;
  assign copy_src = bank_q ? b1_src : b0_src;
  // Write bank is the one not displayed; CLEAR writes both at once
  assign we0      = wr_both | (wr_w & bank_q);
  assign we1      = wr_both | (wr_w & ~bank_q);

  everloop_bank u_bank0 (
    .clk_i     (clk_i),
    .we_i      (we0),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr_a_i (bus.rd_addr),
    .rdata_a_o (b0_disp),
    .raddr_b_i (idx_q),
    .rdata_b_o (b0_src)
  );

  everloop_bank u_bank1 (
    .clk_i     (clk_i),
    .we_i      (we1),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr_a_i (bus.rd_addr),
    .rdata_a_o (b1_disp),
    .raddr_b_i (idx_q),
    .rdata_b_o (b1_src)
  );

  // Next-state, bank write steering and swap bookkeeping
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bank_d      = bank_q;
    frame_cnt_d = frame_cnt_q;
    wr_w        = 1'b0;
    wr_both     = 1'b0;
    waddr       = idx_q;
    wdata       = 8'h00;
    wr_err_d    = accept && !in_range;
    case (state_q)
      ST_CLEAR: begin
        wr_both = 1'b1;
        idx_d   = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          wr_w  = in_range;
          waddr = bus.wr_addr;
          wdata = bus.wr_data;
          if (bus.wr_last) begin
            state_d = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (boundary) begin
          bank_d      = ~bank_q;
          frame_cnt_d = frame_cnt_q + 8'd1;
          idx_d       = '0;
          state_d     = ST_COPY;
        end
      end
      ST_COPY: begin
        // Refresh the new hidden bank so partial updates build on the shown frame
        wr_w  = 1'b1;
        wdata = copy_src;
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign rd_data_d = (state_q == ST_CLEAR) ? 8'h00 : (rd_sel ? b1_disp : b0_disp);

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_CLEAR;
      idx_q       <= '0;
      bank_q      <= 1'b0;
      frame_cnt_q <= 8'h00;
      prev_addr_q <= '0;
      wr_ready_q  <= 1'b0;
      wr_err_q    <= 1'b0;
      rd_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bank_q      <= bank_d;
      frame_cnt_q <= frame_cnt_d;
      prev_addr_q <= bus.rd_addr;
      wr_ready_q  <= (state_d == ST_IDLE);
      wr_err_q    <= wr_err_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign bus.wr_ready  = wr_ready_q;
  assign bus.wr_err    = wr_err_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.pending   = (state_q == ST_PEND);
  assign bus.bank      = bank_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_everloop_fb.sv
// tb/tb_everloop_fb.sv - randomized self-checking bench for everloop_fb
module tb_everloop_fb;
  import everloop_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  everloop_fb_if bus();

  everloop_fb dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame-level reference: two byte banks, busy counters for clear/copy
  logic [7:0] mem_m [2][DEPTH];
  int   m_bank, m_cnt, clear_left, copy_left, prev_ra, ra;
  bit   m_pend, m_ready, exp_err;
  logic [7:0] exp_rd;

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH; i++) mem_m[b][i] = 8'h00;
    m_bank = 0; m_cnt = 0; clear_left = DEPTH; copy_left = 0; prev_ra = 0;
    m_pend = 0; m_ready = 0; exp_err = 0; exp_rd = 8'h00; ra = 0;
  endtask

  task automatic step(input bit v, input int a, input int d, input bit l, input int r);
    bit bnd, swap;
    bus.wr_valid = v; bus.wr_addr = 8'(a); bus.wr_data = 8'(d);
    bus.wr_last = l; bus.rd_addr = 8'(r);
    @(posedge clk);
    bnd  = (r == 0) && (prev_ra == DEPTH - 1);
    swap = m_pend && bnd;
    exp_err = m_ready && v && (a >= DEPTH);
    if (clear_left > 0 || r >= DEPTH) exp_rd = 8'h00;
    else exp_rd = mem_m[swap ? 1 - m_bank : m_bank][r];
    if (clear_left > 0) clear_left--;
    else if (m_ready && v) begin
      if (a < DEPTH) mem_m[1 - m_bank][a] = 8'(d);
      if (l) m_pend = 1;
    end else if (swap) begin
      m_bank = 1 - m_bank;
      m_cnt  = (m_cnt + 1) % 256;
      for (int i = 0; i < DEPTH; i++) mem_m[1 - m_bank][i] = mem_m[m_bank][i];
      copy_left = DEPTH;
      m_pend = 0;
    end else if (copy_left > 0) copy_left--;
    m_ready = (clear_left == 0) && !m_pend && (copy_left == 0);
    prev_ra = r;
    #1;
  endtask

  task automatic sweep(input bit v, input int a, input int d, input bit l);
    step(v, a, d, l, ra);
    ra = (ra + 1) % DEPTH;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!m_ready && n < 1000) begin sweep(0, 0, 0, 0); n++; end
  endtask

  task automatic wait_swap(output int n);
    int b0;
    b0 = m_bank; n = 0;
    while (m_bank == b0 && n < 1000) begin sweep(0, 0, 0, 0); n++; end
    if (m_bank == b0) n = -1;
  endtask

  task automatic clear_phase(input string tag);
    int rise;
    rise = -1;
    for (int c = 1; c <= 400 && rise < 0; c++) begin
      sweep(0, 0, 0, 0);
      checks++;
      if (bus.rd_data !== 8'h00) begin
        errors++; $display("FAIL %s_clear_read got %h want 00", tag, bus.rd_data);
      end
      if (bus.wr_ready === 1'b1) rise = c;
    end
    checks++;
    if (rise != DEPTH) begin
      errors++; $display("FAIL %s_clear_len got %0d want %0d", tag, rise, DEPTH);
    end
    for (int k = 0; k < DEPTH; k++) begin
      sweep(0, 0, 0, 0);
      checks++;
      if (bus.rd_data !== 8'h00 || bus.bank !== 1'b0) begin
        errors++; $display("FAIL %s_zero_frame got %h bank %b want 00 bank 0", tag, bus.rd_data, bus.bank);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.wr_last = 0; bus.rd_addr = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.wr_ready, bus.wr_err, bus.pending, bus.bank, bus.rd_data, bus.frame_cnt} !== 20'h0) begin
      errors++;
      $display("FAIL reset_values got rdy %b err %b pend %b bank %b rd %h cnt %h want all 0",
               bus.wr_ready, bus.wr_err, bus.pending, bus.bank, bus.rd_data, bus.frame_cnt);
    end
    model_reset();
    rst_n = 1'b1;
    clear_phase("reset");
  endtask

  task automatic test_write_commit();
    int n;
    for (int a = 0; a < DEPTH; a++) begin
      sweep(1, a, 8'hAA, a == DEPTH - 1);
      checks++;
      if (bus.wr_ready !== m_ready || bus.pending !== m_pend) begin
        errors++; $display("FAIL commit_hs got rdy %b pend %b want %b %b", bus.wr_ready, bus.pending, m_ready, m_pend);
      end
    end
    wait_swap(n);
    checks++;
    if (n < 0) begin errors++; $display("FAIL commit_swap_timeout got none want swap"); end
    checks++;
    if (bus.rd_data !== 8'hAA) begin
      errors++; $display("FAIL commit_read0 got %h want aa", bus.rd_data);
    end
    checks++;
    if (bus.bank !== 1'b1 || bus.frame_cnt !== 8'd1 || bus.pending !== 1'b0) begin
      errors++; $display("FAIL commit_state got bank %b cnt %0d pend %b want 1 1 0", bus.bank, bus.frame_cnt, bus.pending);
    end
  endtask

  task automatic test_copy();
    int n, a;
    logic [7:0] want;
    n = 0;
    while (!m_ready && n < 1000) begin
      sweep(0, 0, 0, 0); n++;
      checks++;
      if (bus.wr_ready !== m_ready) begin
        errors++; $display("FAIL copy_ready got %b want %b", bus.wr_ready, m_ready);
      end
    end
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL copy_len got %0d want %0d", n, DEPTH); end
    sweep(1, 3, 8'h55, 1);
    wait_swap(n);
    checks++;
    if (n < 0 || bus.rd_data !== 8'hAA) begin
      errors++; $display("FAIL copy_swap got n %0d rd %h want aa", n, bus.rd_data);
    end
    for (int k = 0; k < DEPTH; k++) begin
      a = ra;
      sweep(0, 0, 0, 0);
      want = (a == 3) ? 8'h55 : 8'hAA;
      checks++;
      if (bus.rd_data !== want) begin
        errors++; $display("FAIL copy_frame addr %0d got %h want %h", a, bus.rd_data, want);
      end
    end
    checks++;
    if (bus.frame_cnt !== 8'd2 || bus.bank !== 1'b0) begin
      errors++; $display("FAIL copy_cnt got %0d bank %b want 2 0", bus.frame_cnt, bus.bank);
    end
  endtask

  task automatic test_out_of_range();
    int n, errs_seen, errs_want;
    logic bank_before;
    wait_ready(n);
    bank_before = 1'(m_bank);
    sweep(1, 200, 8'h77, 0);
    checks++;
    if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL oor_err_pulse got %b want 1", bus.wr_err); end
    sweep(0, 0, 0, 0);
    checks++;
    if (bus.wr_err !== 1'b0 || bus.bank !== bank_before) begin
      errors++; $display("FAIL oor_after got err %b bank %b want 0 %b", bus.wr_err, bus.bank, bank_before);
    end
    step(0, 0, 0, 0, 200);
    checks++;
    if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL oor_read got %h want 00", bus.rd_data); end
    errs_seen = 0; errs_want = 0;
    for (int i = 0; i < 60; i++) begin
      bit v;
      v = (i == 59) ? 1'b1 : 1'($urandom_range(0, 1));
      sweep(v, $urandom_range(0, 199), $urandom_range(0, 255), i == 59);
      if (bus.wr_err === 1'b1) errs_seen++;
      if (exp_err) errs_want++;
      checks++;
      if (bus.wr_err !== exp_err) begin errors++; $display("FAIL rand_err got %b want %b", bus.wr_err, exp_err); end
    end
    checks++;
    if (errs_seen != errs_want) begin errors++; $display("FAIL rand_err_count got %0d want %0d", errs_seen, errs_want); end
    wait_swap(n);
    checks++;
    if (n < 0) begin errors++; $display("FAIL rand_swap_timeout got none want swap"); end
    for (int k = 0; k < DEPTH; k++) begin
      sweep(0, 0, 0, 0);
      checks++;
      if (bus.rd_data !== exp_rd) begin errors++; $display("FAIL rand_frame got %h want %h", bus.rd_data, exp_rd); end
    end
  endtask

  task automatic test_simultaneous();
    int n, cnt0, bank0;
    wait_ready(n);
    n = 0;
    while (!(ra == 0 && prev_ra == DEPTH - 1) && n < 1000) begin sweep(0, 0, 0, 0); n++; end
    cnt0 = m_cnt; bank0 = m_bank;
    sweep(1, 10, $urandom_range(0, 255), 1);
    checks++;
    if (bus.pending !== 1'b1 || bus.bank !== 1'(bank0) || bus.frame_cnt !== 8'(cnt0)) begin
      errors++; $display("FAIL simul_noswap got pend %b bank %b cnt %0d want 1 %0d %0d", bus.pending, bus.bank, bus.frame_cnt, bank0, cnt0);
    end
    wait_swap(n);
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL simul_delay got %0d want %0d", n, DEPTH); end
    checks++;
    if (bus.frame_cnt !== 8'((cnt0 + 1) % 256) || bus.bank !== 1'(1 - bank0)) begin
      errors++; $display("FAIL simul_swap got cnt %0d bank %b want %0d %0d", bus.frame_cnt, bus.bank, (cnt0 + 1) % 256, 1 - bank0);
    end
  endtask

  task automatic test_reset_mid_copy();
    int n;
    wait_ready(n);
    sweep(1, 5, 8'h3C, 1);
    wait_swap(n);
    repeat (50) sweep(0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.bank, bus.frame_cnt, bus.pending, bus.wr_ready, bus.rd_data} !== 19'h0) begin
      errors++; $display("FAIL rstcopy_values got bank %b cnt %0d pend %b rdy %b rd %h want all 0",
                         bus.bank, bus.frame_cnt, bus.pending, bus.wr_ready, bus.rd_data);
    end
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    clear_phase("rstcopy");
  endtask

  initial begin
    test_reset();
    test_write_commit();
    test_copy();
    test_out_of_range();
    test_simultaneous();
    test_reset_mid_copy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
